// File: rtl/freq_pkg.sv
// Shared constants for the frequency generator and the frequency meter.
// Holds clock rate, NCO width, FSM encodings and meter gate timing.
package freq_pkg;

    localparam logic [31:0] SYS_CLK_FREQ = 32'd50_000_000;
    localparam int          ACC_W        = 32;

    // Highest frequency the generator can represent as a square wave.
    localparam logic [31:0] F_MAX = SYS_CLK_FREQ / 32'd2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_LOAD = 2'd2;

    // Meter gate window: one second of sys_clk, so counts read in Hz.
    localparam logic [31:0] GATE_CYCLES = SYS_CLK_FREQ;

endpackage

// File: rtl/freq_gen_div.sv
// Iterative restoring divider: quot = floor(dividend * 2^QW / DIVISOR).
// Ports: clk, rst_n, start (load dividend), done (final iteration), quot.
module freq_gen_div #(
    parameter logic [31:0] DIVISOR = 32'd50_000_000,
    parameter int          QW      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [31:0]   dividend,
    output logic          done,
    output logic [QW-1:0] quot
);

    localparam int          CW    = $clog2(QW);
    localparam logic [32:0] DIV33 = {1'b0, DIVISOR};

    logic [32:0]   rem;
    logic [32:0]   rem_sh;
    logic [CW-1:0] cnt;
    logic          run;

    // rem < DIVISOR < 2^32 always holds, so the shift never loses a bit.
    assign rem_sh = rem << 1;
    assign done   = run && (cnt == CW'(QW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            quot <= '0;
        end else if (start) begin
            rem  <= {1'b0, dividend};
            cnt  <= '0;
            run  <= 1'b1;
            quot <= '0;
        end else if (run) begin
            if (rem_sh >= DIV33) begin
                rem  <= rem_sh - DIV33;
                quot <= {quot[QW-2:0], 1'b1};
            end else begin
                rem  <= rem_sh;
                quot <= {quot[QW-2:0], 1'b0};
            end
            cnt <= cnt + 1'b1;
            if (done) begin
                run <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/freq_gen_nco.sv
// Programmable square-wave NCO: Hz request -> tuning word -> clk_out.
// Ports: sys_clk, sys_rst_n, freq_set/set_vld in; busy, set_done, ftw, clk_out out.
module freq_gen_nco
    import freq_pkg::*;
#(
    parameter logic [31:0] SYS_CLK_FREQ = freq_pkg::SYS_CLK_FREQ,
    parameter int          ACC_W        = freq_pkg::ACC_W
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [31:0]      freq_set,
    input  logic             set_vld,
    output logic             busy,
    output logic             set_done,
    output logic [ACC_W-1:0] ftw,
    output logic             clk_out
);

    localparam logic [31:0] F_LIM = SYS_CLK_FREQ / 32'd2;

    logic [1:0]       state;
    logic [31:0]      f_clamp;
    logic             start;
    logic             div_done;
    logic [ACC_W-1:0] quot;
    logic [ACC_W-1:0] acc;

    assign f_clamp = (freq_set > F_LIM) ? F_LIM : freq_set;
    assign start   = (state == ST_IDLE) && set_vld;

    freq_gen_div #(
        .DIVISOR (SYS_CLK_FREQ),
        .QW      (ACC_W)
    ) u_div (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .start    (start),
        .dividend (f_clamp),
        .done     (div_done),
        .quot     (quot)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            set_done <= 1'b0;
            ftw      <= '0;
        end else begin
            set_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (set_vld) begin
                        state <= ST_CALC;
                        busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (div_done) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ftw      <= quot;
                    set_done <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Accumulator is never cleared on update, keeping the output
    // phase-continuous; a zero tuning word parks it at 0.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            acc     <= '0;
            clk_out <= 1'b0;
        end else begin
            clk_out <= acc[ACC_W-1];
            acc     <= (ftw == '0) ? '0 : acc + ftw;
        end
    end

endmodule

// File: tb/tb_freq_gen_nco.sv
// Directed self-checking bench for freq_gen_nco.
// Each task drives one scenario and checks against hand-computed values.
module tb_freq_gen_nco;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic [31:0] freq_set = 32'd0;
    logic        set_vld  = 1'b0;
    logic        busy;
    logic        set_done;
    logic [31:0] ftw;
    logic        clk_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    freq_gen_nco dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .freq_set  (freq_set),
        .set_vld   (set_vld),
        .busy      (busy),
        .set_done  (set_done),
        .ftw       (ftw),
        .clk_out   (clk_out)
    );

    // Returns just after accept edge N.
    task automatic start_req(input logic [31:0] f);
        @(negedge clk);
        freq_set = f;
        set_vld  = 1'b1;
        @(posedge clk);
        #1;
        set_vld = 1'b0;
    endtask

    // Edges after the current one until set_done is seen; -1 on timeout.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (set_done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int hi;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || set_done !== 1'b0 || clk_out !== 1'b0 || ftw !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b clk_out=%b ftw=%0d, required all 0",
                     busy, set_done, clk_out, ftw);
        end
        @(negedge clk);
        rst_n = 1'b1;
        hi = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (clk_out !== 1'b0 || busy !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL reset_idle: %0d bad cycles, required 0", hi);
        end
    endtask

    task automatic test_1mhz;
        int k;
        int edges;
        logic prev;
        start_req(32'd1_000_000);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_accept: busy=%b, required 1", busy);
        end
        wait_done(k);
        checks++;
        if (k != 33) begin
            errors++;
            $display("FAIL done_latency_1m: edge N+%0d, required N+33", k);
        end
        checks++;
        if (ftw !== 32'd85_899_345) begin
            errors++;
            $display("FAIL ftw_1m: ftw=%0d, required 85899345", ftw);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_done: busy=%b, required 0", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (set_done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: set_done=%b, required 0", set_done);
        end
        edges = 0;
        prev  = clk_out;
        for (int i = 0; i < 50_000; i++) begin
            @(posedge clk);
            #1;
            if (clk_out && !prev) edges++;
            prev = clk_out;
        end
        checks++;
        if (edges < 999 || edges > 1001) begin
            errors++;
            $display("FAIL edges_1m: %0d rising edges, required 1000 +/-1", edges);
        end
    endtask

    task automatic test_clamp;
        int k;
        start_req(32'd30_000_000);
        wait_done(k);
        checks++;
        if (k != 33 || ftw !== 32'd2_147_483_648) begin
            errors++;
            $display("FAIL clamp_30m: k=%0d ftw=%0d, required k=33 ftw=2147483648", k, ftw);
        end
    endtask

    task automatic test_max;
        int k;
        int bad;
        logic prev;
        start_req(32'd25_000_000);
        wait_done(k);
        checks++;
        if (k != 33 || ftw !== 32'd2_147_483_648) begin
            errors++;
            $display("FAIL ftw_25m: k=%0d ftw=%0d, required k=33 ftw=2147483648", k, ftw);
        end
        repeat (3) @(posedge clk);
        #1;
        prev = clk_out;
        bad  = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk);
            #1;
            if (clk_out === prev) bad++;
            prev = clk_out;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL toggle_25m: %0d cycles without toggle, required 0", bad);
        end
    endtask

    task automatic test_zero_one;
        int k;
        int hi;
        start_req(32'd0);
        wait_done(k);
        checks++;
        if (k != 33 || ftw !== 32'd0) begin
            errors++;
            $display("FAIL ftw_zero: k=%0d ftw=%0d, required k=33 ftw=0", k, ftw);
        end
        repeat (3) @(posedge clk);
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (clk_out !== 1'b0) hi++;
        end
        checks++;
        if (hi != 0) begin
            errors++;
            $display("FAIL hold_zero: clk_out high %0d cycles, required 0", hi);
        end
        start_req(32'd1);
        wait_done(k);
        checks++;
        if (k != 33 || ftw !== 32'd85) begin
            errors++;
            $display("FAIL ftw_one: k=%0d ftw=%0d, required k=33 ftw=85", k, ftw);
        end
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (clk_out !== 1'b0) begin
            errors++;
            $display("FAIL slow_start: clk_out=%b, required 0", clk_out);
        end
    endtask

    task automatic test_busy_ignore;
        int k;
        int extra;
        start_req(32'd1_000_000);
        repeat (4) @(posedge clk);
        #1;
        freq_set = 32'd5_000_000;
        set_vld  = 1'b1;
        @(posedge clk);
        #1;
        set_vld = 1'b0;
        wait_done(k);
        checks++;
        if (k != 28 || ftw !== 32'd85_899_345) begin
            errors++;
            $display("FAIL busy_ignore: k=%0d ftw=%0d, required k=28 ftw=85899345", k, ftw);
        end
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (set_done || busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL busy_ignore_extra: %0d busy/done cycles, required 0", extra);
        end
    endtask

    task automatic test_back_to_back;
        int exp_c[3] = '{33, 67, 101};
        logic [31:0] exp_f[3] = '{32'd85, 32'd171, 32'd257};
        int n;
        n = 0;
        @(negedge clk);
        freq_set = 32'd1;
        set_vld  = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 110; c++) begin
            @(posedge clk);
            #1;
            if (c == 1)  freq_set = 32'd2;
            if (c == 35) freq_set = 32'd3;
            if (c == 68) set_vld  = 1'b0;
            if (set_done) begin
                checks++;
                if (n >= 3) begin
                    errors++;
                    $display("FAIL b2b_extra: set_done at N+%0d, required none", c);
                end else if (c != exp_c[n] || ftw !== exp_f[n]) begin
                    errors++;
                    $display("FAIL b2b_%0d: at N+%0d ftw=%0d, required N+%0d ftw=%0d",
                             n, c, ftw, exp_c[n], exp_f[n]);
                end
                n++;
            end
        end
        set_vld = 1'b0;
        checks++;
        if (n != 3) begin
            errors++;
            $display("FAIL b2b_count: %0d set_done pulses, required 3", n);
        end
    endtask

    task automatic test_reset_mid;
        int bad;
        start_req(32'd25_000_000);
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || set_done !== 1'b0 || clk_out !== 1'b0 || ftw !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: busy=%b done=%b clk_out=%b ftw=%0d, required all 0",
                     busy, set_done, clk_out, ftw);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (set_done || busy || clk_out || ftw != 32'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_lost: %0d active cycles, required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_1mhz();
        test_clamp();
        test_max();
        test_zero_one();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
